// File: rtl/monitor_termico_multicanal_pkg.sv
// Shared definitions for the multi-channel thermal monitor: FSM codes,
// display-code width, channel-index width helper and a channel-slice macro.
`ifndef MONITOR_TERMICO_MULTICANAL_PKG_SV
`define MONITOR_TERMICO_MULTICANAL_PKG_SV

// Extracts channel i (width w) from a packed multi-channel vector v.
`define MTM_CANAL(v, i, w) v[(i)*(w) +: (w)]

package monitor_termico_multicanal_pkg;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    REPOSO  = 2'b00,
    LEER    = 2'b01,
    DECIDIR = 2'b10,
    ALERTA  = 2'b11
  } estado_e;

  // Width of the hottest-channel index; at least one bit even for a single channel.
  function automatic int canal_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/monitor_termico_multicanal_antirrebote_bit.sv
// Single-bit input conditioner: 2-FF synchroniser followed by a debouncer
// that adopts the synchronised value after DEB_CYCLES consecutive cycles
// of disagreement, emitting a one-cycle pulse when it does.
module antirrebote_bit #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic dato_o,
  output logic pulso_listo_o
);

  localparam int              CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             dato_q, dato_d;
  logic             pulso_q, pulso_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; the DEB_CYCLES-th one commits the new value.
  always_comb begin
    dato_d  = dato_q;
    pulso_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != dato_q) begin
      if (cnt_q == CNT_LIM) begin
        dato_d  = sync2_q;
        pulso_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dato_q  <= 1'b0;
      pulso_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      dato_q  <= dato_d;
      pulso_q <= pulso_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dato_o        = dato_q;
  assign pulso_listo_o = pulso_q;

endmodule

// File: rtl/monitor_termico_multicanal.sv
// Multi-channel thermal monitor: debounced temperature/presence/fire inputs,
// hottest-channel search, hysteretic ventilation and a latched, acknowledgeable alarm.
module monitor_termico_multicanal
  import monitor_termico_multicanal_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int TEMP_W     = 5,
  parameter int DEB_CYCLES = 16,
  parameter int T_VENT_ON  = 20,
  parameter int T_VENT_OFF = 17,
  parameter int T_ALARM    = 28,
  parameter int ALARM_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*TEMP_W-1:0]     temperatura,
  input  logic                       presencia,
  input  logic                       ignicion,
  input  logic                       ack,
  output logic                       ventilacion,
  output logic                       alarma,
  output logic [ESTADO_W-1:0]        estado,
  output logic [TEMP_W-1:0]          temp_max,
  output logic [canal_w(N_CH)-1:0]   canal_max,
  output logic                       dato_listo
);

  localparam int CW     = canal_w(N_CH);
  localparam int NT     = N_CH * TEMP_W;
  localparam int NB     = NT + 2;
  localparam int HOLD_W = $clog2(ALARM_HOLD + 1);

  localparam logic [TEMP_W-1:0] VENT_ON_L  = TEMP_W'(T_VENT_ON);
  localparam logic [TEMP_W-1:0] VENT_OFF_L = TEMP_W'(T_VENT_OFF);
  localparam logic [TEMP_W-1:0] ALARM_L    = TEMP_W'(T_ALARM);
  localparam logic [HOLD_W-1:0] HOLD_INI   = HOLD_W'(ALARM_HOLD);

  if (N_CH < 1 || N_CH > 8 || DEB_CYCLES < 2 || T_VENT_OFF >= T_VENT_ON ||
      T_VENT_ON > T_ALARM || T_ALARM >= (1 << TEMP_W) || ALARM_HOLD < 1) begin : g_param_err
    $error("monitor_termico_multicanal: invalid parameter combination");
  end

  logic [NB-1:0]     raw_in, deb, pulso;
  logic [NT-1:0]     temp_deb;
  logic              pres_deb, ign_deb;
  logic [TEMP_W-1:0] max_live;
  logic [CW-1:0]     canal_live;

  estado_e           state_q, state_d;
  logic              vent_q, vent_d;
  logic              alarma_q, alarma_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TEMP_W-1:0] tmax_q, tmax_d;
  logic [CW-1:0]     cmax_q, cmax_d;

  assign raw_in = {ignicion, presencia, temperatura};

  for (genvar b = 0; b < NB; b++) begin : g_deb
    antirrebote_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk          (clk),
      .rst_n        (rst),
      .raw_i        (raw_in[b]),
      .dato_o       (deb[b]),
      .pulso_listo_o(pulso[b])
    );
  end

  assign temp_deb   = deb[NT-1:0];
  assign pres_deb   = deb[NT];
  assign ign_deb    = deb[NT+1];
  assign dato_listo = |pulso;

  // Live maximum over debounced channels; strict '>' keeps the lowest index on ties.
  always_comb begin
    max_live   = '0;
    canal_live = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (`MTM_CANAL(temp_deb, i, TEMP_W) > max_live) begin
        max_live   = `MTM_CANAL(temp_deb, i, TEMP_W);
        canal_live = CW'(i);
      end
    end
  end

  // Next-state, ventilation hysteresis, alarm latch and hold countdown.
  always_comb begin
    state_d  = state_q;
    vent_d   = vent_q;
    alarma_d = alarma_q;
    hold_d   = hold_q;
    tmax_d   = tmax_q;
    cmax_d   = cmax_q;
    unique case (state_q)
      REPOSO: state_d = LEER;
      LEER: begin
        if (dato_listo) state_d = DECIDIR;
      end
      DECIDIR: begin
        tmax_d = max_live;
        cmax_d = canal_live;
        if (!pres_deb || max_live <= VENT_OFF_L) begin
          vent_d = 1'b0;
        end else if (max_live >= VENT_ON_L) begin
          vent_d = 1'b1;
        end
        if (ign_deb || max_live >= ALARM_L) begin
          state_d  = ALERTA;
          alarma_d = 1'b1;
          hold_d   = HOLD_INI;
        end else begin
          state_d = LEER;
        end
      end
      ALERTA: begin
        // Forced value persists after exit until the next DECIDIR.
        vent_d = ~ign_deb;
        if (hold_q != '0) hold_d = hold_q - 1'b1;
        if (hold_q == '0 && ack && !ign_deb && max_live < ALARM_L) begin
          state_d  = LEER;
          alarma_d = 1'b0;
        end
      end
      default: state_d = REPOSO;
    endcase
  end

  // Registered state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= REPOSO;
      vent_q   <= 1'b0;
      alarma_q <= 1'b0;
      hold_q   <= '0;
      tmax_q   <= '0;
      cmax_q   <= '0;
    end else begin
      state_q  <= state_d;
      vent_q   <= vent_d;
      alarma_q <= alarma_d;
      hold_q   <= hold_d;
      tmax_q   <= tmax_d;
      cmax_q   <= cmax_d;
    end
  end

  assign estado      = state_q;
  assign ventilacion = vent_q;
  assign alarma      = alarma_q;
  assign temp_max    = tmax_q;
  assign canal_max   = cmax_q;

endmodule

// File: tb/tb_monitor_termico_multicanal.sv
// Self-checking bench for monitor_termico_multicanal (4-channel and 1-channel builds).
module tb_monitor_termico_multicanal;

  localparam int N_CH = 4;
  localparam int TW   = 5;
  localparam int DEB  = 16;
  localparam int VON  = 20;
  localparam int VOFF = 17;
  localparam int TAL  = 28;
  localparam int HOLD = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_CH*TW-1:0] temperatura = '0;
  logic [TW-1:0]     temp1 = '0;
  logic              presencia = 1'b0, ignicion = 1'b0, ack = 1'b0;

  logic              ventilacion, alarma, dato_listo;
  logic [1:0]        estado, canal_max;
  logic [TW-1:0]     temp_max;
  logic              vent1, alarma1, dato1, cmax1;
  logic [1:0]        estado1;
  logic [TW-1:0]     tmax1;

  always #5 clk = ~clk;

  monitor_termico_multicanal #(
    .N_CH(N_CH), .TEMP_W(TW), .DEB_CYCLES(DEB), .T_VENT_ON(VON),
    .T_VENT_OFF(VOFF), .T_ALARM(TAL), .ALARM_HOLD(HOLD)
  ) u_dut (
    .clk(clk), .rst(rst), .temperatura(temperatura), .presencia(presencia),
    .ignicion(ignicion), .ack(ack), .ventilacion(ventilacion), .alarma(alarma),
    .estado(estado), .temp_max(temp_max), .canal_max(canal_max), .dato_listo(dato_listo)
  );

  monitor_termico_multicanal #(
    .N_CH(1), .TEMP_W(TW), .DEB_CYCLES(DEB), .T_VENT_ON(VON),
    .T_VENT_OFF(VOFF), .T_ALARM(TAL), .ALARM_HOLD(HOLD)
  ) u_dut1 (
    .clk(clk), .rst(rst), .temperatura(temp1), .presencia(presencia),
    .ignicion(ignicion), .ack(ack), .ventilacion(vent1), .alarma(alarma1),
    .estado(estado1), .temp_max(tmax1), .canal_max(cmax1), .dato_listo(dato1)
  );

  int checks = 0, errors = 0;
  int pulses = 0, pulses1 = 0, snap = 0, snap1 = 0;

  always @(negedge clk) begin
    if (dato_listo === 1'b1) pulses++;
    if (dato1 === 1'b1) pulses1++;
  end

  // Reference model: settled inputs and the expected system response.
  logic [TW-1:0] t_m[N_CH];
  logic [TW-1:0] t1_m = '0;
  logic          p_m = 1'b0, i_m = 1'b0;
  logic [21:0]   last_in = '0;
  logic          alarm_m = 1'b0, vent_m = 1'b0;
  logic [TW-1:0] tmax_m = '0;
  logic [1:0]    cmax_m = '0;
  int            exp_pulses = 0;

  function automatic logic [21:0] pack_in();
    return {t_m[3], t_m[2], t_m[1], t_m[0], p_m, i_m};
  endfunction

  function automatic int max_m();
    int m = 0;
    for (int i = 0; i < N_CH; i++) if (int'(t_m[i]) > m) m = int'(t_m[i]);
    return m;
  endfunction

  function automatic logic [10:0] exp_vec();
    return {alarm_m ? 2'b11 : 2'b01, alarm_m, vent_m, tmax_m, cmax_m};
  endfunction

  function automatic void decide();
    int m = max_m();
    for (int i = N_CH - 1; i >= 0; i--) if (int'(t_m[i]) == m) cmax_m = 2'(i);
    tmax_m = TW'(m);
    if (!p_m || m <= VOFF) vent_m = 1'b0;
    else if (m >= VON)     vent_m = 1'b1;
    if (i_m || m >= TAL) alarm_m = 1'b1;
  endfunction

  function automatic void model_apply();
    logic [21:0] cur = pack_in();
    exp_pulses = (cur != last_in) ? 1 : 0;
    if (cur != last_in && !alarm_m) decide();
    if (alarm_m) vent_m = ~i_m;
    last_in = cur;
  endfunction

  task automatic drive_now();
    temperatura = {t_m[3], t_m[2], t_m[1], t_m[0]};
    temp1       = t1_m;
    presencia   = p_m;
    ignicion    = i_m;
  endtask

  task automatic step();
    @(posedge clk); #1;
    snap = pulses; snap1 = pulses1;
    drive_now();
    repeat (40) @(posedge clk);
    #1;
    model_apply();
  endtask

  task automatic ack_step();
    @(posedge clk); #1 ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (alarm_m && !i_m && max_m() < TAL) alarm_m = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({estado, alarma, ventilacion, temp_max, canal_max, dato_listo} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values got=%h exp=000", {estado, alarma, ventilacion, temp_max, canal_max, dato_listo});
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (estado !== 2'b01) begin
      errors++;
      $display("FAIL reset_release_estado got=%b exp=01", estado);
    end
  endtask

  task automatic test_ventilacion();
    logic [TW-1:0] seq[4]  = '{5'd15, 5'd21, 5'd18, 5'd16};
    logic          vseq[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    p_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t_m[2] = seq[k];
      t1_m   = seq[k];
      step();
      checks++;
      if (exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
        errors++;
        $display("FAIL vent_model[%0d] got=%h exp=%h", k, {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
      end
      checks++;
      if ({ventilacion, canal_max} !== {vseq[k], 2'd2}) begin
        errors++;
        $display("FAIL vent_seq[%0d] got=%b exp=%b", k, {ventilacion, canal_max}, {vseq[k], 2'd2});
      end
      checks++;
      if ({vent1, tmax1, cmax1, estado1, alarma1} !== {vseq[k], seq[k], 1'b0, 2'b01, 1'b0}) begin
        errors++;
        $display("FAIL vent_1ch[%0d] got=%h exp=%h", k, {vent1, tmax1, cmax1, estado1, alarma1}, {vseq[k], seq[k], 1'b0, 2'b01, 1'b0});
      end
      checks++;
      if (pulses - snap != exp_pulses || pulses1 - snap1 != 1) begin
        errors++;
        $display("FAIL vent_pulses[%0d] got=%0d/%0d exp=%0d/1", k, pulses - snap, pulses1 - snap1, exp_pulses);
      end
    end
  endtask

  task automatic test_antirrebote();
    int glitch[2] = '{10, DEB - 1};
    int lat;
    for (int g = 0; g < 2; g++) begin
      @(posedge clk); #1;
      snap = pulses;
      temperatura[0] = ~temperatura[0];
      repeat (glitch[g]) @(posedge clk);
      #1 temperatura[0] = ~temperatura[0];
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (pulses - snap != 0) begin
        errors++;
        $display("FAIL glitch_%0d_pulses got=%0d exp=0", glitch[g], pulses - snap);
      end
      checks++;
      if (exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
        errors++;
        $display("FAIL glitch_%0d_outputs got=%h exp=%h", glitch[g], {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
      end
    end
    t_m[0] = t_m[0] ^ 5'd1;
    @(posedge clk); #1;
    snap = pulses;
    drive_now();
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (dato_listo === 1'b1) break;
    end
    checks++;
    if (lat != 2 + DEB) begin
      errors++;
      $display("FAIL deb_latency got=%0d exp=%0d", lat, 2 + DEB);
    end
    repeat (20) @(posedge clk);
    #1;
    model_apply();
    checks++;
    if (pulses - snap != 1 || exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
      errors++;
      $display("FAIL deb_level got=%0d/%h exp=1/%h", pulses - snap, {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
    end
  endtask

  task automatic test_alerta_empate();
    int lat;
    t_m[0] = 5'd29; t_m[1] = 5'd0; t_m[2] = 5'd0; t_m[3] = 5'd29;
    @(posedge clk); #1;
    drive_now();
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (estado === 2'b11) break;
    end
    checks++;
    if (estado !== 2'b11) begin
      errors++;
      $display("FAIL tie_enter_alerta got=%b exp=11", estado);
    end
    repeat (2) @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({estado, alarma} !== 3'b111) begin
      errors++;
      $display("FAIL early_ack_ignored got=%b exp=111", {estado, alarma});
    end
    repeat (30) @(posedge clk);
    #1;
    model_apply();
    checks++;
    if ({temp_max, canal_max} !== {5'd29, 2'd0} || exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
      errors++;
      $display("FAIL tie_max got=%h exp=%h", {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
    end
    t_m[0] = 5'd25; t_m[3] = 5'd25;
    step();
    checks++;
    if (exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
      errors++;
      $display("FAIL cooled_in_alerta got=%h exp=%h", {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
    end
    ack_step();
    checks++;
    if ({estado, alarma} !== 3'b010 || exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
      errors++;
      $display("FAIL ack_exit got=%h exp=%h", {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
    end
  endtask

  task automatic test_ignicion();
    for (int i = 0; i < N_CH; i++) t_m[i] = 5'd10;
    p_m = 1'b1; i_m = 1'b1;
    step();
    checks++;
    if ({estado, alarma, ventilacion} !== 4'b1110 || exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
      errors++;
      $display("FAIL fire_alerta got=%h exp=%h", {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
    end
    ack_step();
    checks++;
    if (estado !== 2'b11 || alarma !== 1'b1) begin
      errors++;
      $display("FAIL fire_ack_blocked got=%b exp=111", {estado, alarma});
    end
    i_m = 1'b0;
    step();
    checks++;
    if (exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
      errors++;
      $display("FAIL fire_cleared got=%h exp=%h", {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
    end
    ack_step();
    checks++;
    if (exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
      errors++;
      $display("FAIL fire_ack_exit got=%h exp=%h", {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
    end
  endtask

  task automatic test_aleatorio(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < N_CH; i++) t_m[i] = TW'($urandom_range(0, 31));
      p_m = 1'($urandom_range(0, 1));
      i_m = ($urandom_range(0, 5) == 0);
      step();
      checks++;
      if (pulses - snap != exp_pulses || exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
        errors++;
        $display("FAIL random[%0d] got=%0d/%h exp=%0d/%h", k, pulses - snap, {estado, alarma, ventilacion, temp_max, canal_max}, exp_pulses, exp_vec());
      end
      checks++;
      if (cmax1 !== 1'b0) begin
        errors++;
        $display("FAIL random_1ch_canal[%0d] got=%b exp=0", k, cmax1);
      end
      if (alarm_m && $urandom_range(0, 1) == 1) begin
        ack_step();
        checks++;
        if (exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
          errors++;
          $display("FAIL random_ack[%0d] got=%h exp=%h", k, {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset_alerta();
    i_m = 1'b1;
    step();
    checks++;
    if (alarma !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_alarma got=%b exp=1", alarma);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({estado, alarma, ventilacion, temp_max, canal_max, dato_listo} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_alerta got=%h exp=000", {estado, alarma, ventilacion, temp_max, canal_max, dato_listo});
    end
    for (int i = 0; i < N_CH; i++) t_m[i] = '0;
    t1_m = '0; p_m = 1'b0; i_m = 1'b0;
    drive_now();
    alarm_m = 1'b0; vent_m = 1'b0; tmax_m = '0; cmax_m = '0; last_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (estado !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_alerta_release got=%b exp=01", estado);
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (exp_vec() !== {estado, alarma, ventilacion, temp_max, canal_max}) begin
      errors++;
      $display("FAIL reset_mid_alerta_idle got=%h exp=%h", {estado, alarma, ventilacion, temp_max, canal_max}, exp_vec());
    end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) t_m[i] = '0;
    test_reset();
    test_ventilacion();
    test_antirrebote();
    test_alerta_empate();
    test_ignicion();
    test_aleatorio(30);
    test_reset_alerta();
    test_aleatorio(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
